// File: rtl/qsys_timer_pkg.sv
// Register map and bit positions shared by the multi-channel timer.
package qsys_timer_pkg;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  // STATUS bits
  localparam int unsigned ST_TO  = 0;
  localparam int unsigned ST_RUN = 1;

  // CONTROL bits; prescale field starts at CT_PRESC
  localparam int unsigned CT_ITO   = 0;
  localparam int unsigned CT_CONT  = 1;
  localparam int unsigned CT_START = 2;
  localparam int unsigned CT_STOP  = 3;
  localparam int unsigned CT_CASC  = 4;
  localparam int unsigned CT_PRESC = 8;

endpackage

// File: rtl/qsys_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel timer.
interface qsys_multi_timer_if #(
  parameter int unsigned AddrW = 4
) ();

  logic [AddrW-1:0] address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/qsys_timer_channel.sv
// One timer channel: prescaler, down-counter, control, sticky TO and snapshot.
// Cascade support is built only with QSYS_MULTI_TIMER_CASCADE_EN defined.
module qsys_timer_channel
  import qsys_timer_pkg::*;
#(
  parameter int unsigned       ChIdx       = 0,
  parameter int unsigned       CountW      = 32,
  parameter int unsigned       PrescaleW   = 8,
  parameter logic [CountW-1:0] ResetPeriod = 9
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_i,
  input  logic [1:0]  reg_i,
  input  logic [31:0] wdata_i,
  input  logic        casc_tick_i,
  output logic        timeout_o,
  output logic        irq_o,
  output logic [31:0] rdata_o
);

  logic                 to_q, to_d, run_q, run_d, ito_q, ito_d, cont_q, cont_d;
  logic                 pend_q, pend_d;
  logic [PrescaleW-1:0] presc_q, presc_d, psc_q, psc_d;
  logic [CountW-1:0]    period_q, period_d, cnt_q, cnt_d, snap_q, snap_d;
  logic                 casc_q, casc_en, tick;
  logic                 wr_status, wr_control, wr_period, wr_snap;
  logic                 unused_wdata;

`ifdef QSYS_MULTI_TIMER_CASCADE_EN
  logic casc_d;

  // Cascade select register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) casc_q <= 1'b0;
    else         casc_q <= casc_d;
  end
`else
  assign casc_q = 1'b0;
`endif

  // Channel 0 has no predecessor, so its CASC bit never takes effect.
  assign casc_en      = casc_q && (ChIdx != 0);
  assign wr_status    = wr_i && (reg_i == REG_STATUS);
  assign wr_control   = wr_i && (reg_i == REG_CONTROL);
  assign wr_period    = wr_i && (reg_i == REG_PERIOD);
  assign wr_snap      = wr_i && (reg_i == REG_SNAP);
  assign tick         = run_q && (casc_en ? casc_tick_i : (psc_q == '0));
  assign timeout_o    = tick && (cnt_q == '0);
  assign irq_o        = to_q & ito_q;
  assign unused_wdata = ^wdata_i;

  // Next-state: counting first, then forced reload, then register writes.
  always_comb begin
    to_d     = to_q;
    run_d    = run_q;
    ito_d    = ito_q;
    cont_d   = cont_q;
    presc_d  = presc_q;
    psc_d    = psc_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    pend_d   = 1'b0;
`ifdef QSYS_MULTI_TIMER_CASCADE_EN
    casc_d   = casc_q;
`endif
    if (run_q) psc_d = (psc_q == '0) ? presc_q : psc_q - PrescaleW'(1);
    if (tick)  cnt_d = (cnt_q == '0) ? period_q : cnt_q - CountW'(1);
    if (timeout_o && !cont_q) run_d = 1'b0;
    if (pend_q) begin
      cnt_d = period_q;
      psc_d = presc_q;
      run_d = 1'b0;
    end
    // A timeout in the same cycle as a STATUS write keeps TO set.
    if (timeout_o)      to_d = 1'b1;
    else if (wr_status) to_d = 1'b0;
    if (wr_control) begin
      ito_d   = wdata_i[CT_ITO];
      cont_d  = wdata_i[CT_CONT];
      presc_d = wdata_i[CT_PRESC +: PrescaleW];
`ifdef QSYS_MULTI_TIMER_CASCADE_EN
      casc_d  = wdata_i[CT_CASC];
`endif
      if (wdata_i[CT_STOP]) run_d = 1'b0;
      if (wdata_i[CT_START]) begin
        run_d = 1'b1;
        psc_d = wdata_i[CT_PRESC +: PrescaleW];
      end
    end
    if (wr_period) begin
      period_d = wdata_i[CountW-1:0];
      pend_d   = 1'b1;
    end
    if (wr_snap) snap_d = cnt_q;
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_q     <= 1'b0;
      run_q    <= 1'b0;
      ito_q    <= 1'b0;
      cont_q   <= 1'b0;
      pend_q   <= 1'b0;
      presc_q  <= '0;
      psc_q    <= '0;
      period_q <= ResetPeriod;
      cnt_q    <= ResetPeriod;
      snap_q   <= '0;
    end else begin
      to_q     <= to_d;
      run_q    <= run_d;
      ito_q    <= ito_d;
      cont_q   <= cont_d;
      pend_q   <= pend_d;
      presc_q  <= presc_d;
      psc_q    <= psc_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
    end
  end

  // Register read view for the selected offset.
  always_comb begin
    rdata_o = '0;
    case (reg_i)
      REG_STATUS: begin
        rdata_o[ST_TO]  = to_q;
        rdata_o[ST_RUN] = run_q;
      end
      REG_CONTROL: begin
        rdata_o[CT_ITO]                   = ito_q;
        rdata_o[CT_CONT]                  = cont_q;
        rdata_o[CT_CASC]                  = casc_q;
        rdata_o[CT_PRESC +: PrescaleW]    = presc_q;
      end
      REG_PERIOD: rdata_o[CountW-1:0] = period_q;
      REG_SNAP:   rdata_o[CountW-1:0] = snap_q;
      default:    rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/qsys_multi_timer.sv
// Multi-channel interval timer on an Avalon-MM slave.
// Define QSYS_MULTI_TIMER_CASCADE_EN to allow channel i to count channel i-1 timeouts.
module qsys_multi_timer
  import qsys_timer_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned COUNT_W      = 32,
  parameter int unsigned PRESCALE_W   = 8,
  parameter int unsigned RESET_PERIOD = 9
) (
  input  logic                clk,
  input  logic                reset_n,
  qsys_multi_timer_if.slave   bus,
  output logic                irq
);

  logic [31:0]       ch_idx;
  logic              wr_en;
  logic [NUM_CH-1:0] ch_wr, ch_timeout, ch_irq, ch_casc;
  logic [31:0]       ch_rdata [NUM_CH];
  logic [31:0]       rd_mux, readdata_q;

  assign ch_idx = 32'(bus.address) >> 2;
  assign wr_en  = bus.chipselect & ~bus.write_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_wr[i] = wr_en && (ch_idx == 32'(i));

    if (i == 0) begin : g_first
      assign ch_casc[i] = 1'b0;
    end else begin : g_chain
      assign ch_casc[i] = ch_timeout[i-1];
    end

    qsys_timer_channel #(
      .ChIdx      (i),
      .CountW     (COUNT_W),
      .PrescaleW  (PRESCALE_W),
      .ResetPeriod(COUNT_W'(RESET_PERIOD))
    ) u_ch (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .wr_i       (ch_wr[i]),
      .reg_i      (bus.address[1:0]),
      .wdata_i    (bus.writedata),
      .casc_tick_i(ch_casc[i]),
      .timeout_o  (ch_timeout[i]),
      .irq_o      (ch_irq[i]),
      .rdata_o    (ch_rdata[i])
    );
  end

  // Channel select for reads; unpopulated channels read 0.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 32'(i)) rd_mux = ch_rdata[i];
    end
  end

  // Registered read data, captured on any selected cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            readdata_q <= '0;
    else if (bus.chipselect) readdata_q <= rd_mux;
  end

  assign bus.readdata = readdata_q;
  assign irq          = |ch_irq;

endmodule
